// File: rtl/sort_seq_pkg.sv
// sort_seq_pkg
// Shared definitions for the sequential sorter: FSM state encoding,
// comparator result bit positions and the fixed comparator width.
// Optional build macro used by the sorter: SORT_SEQ_DESC_EN.
package sort_seq_pkg;

  localparam int WIDTH_C    = 4;

  // Comparator result vector R: one-hot, exactly one bit set per compare.
  localparam int CMP_GT_BIT = 2;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 0;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// sort_seq_ctrl_if
// Bundles the sample input stream and the sorted output stream.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender keeps data (and out_last)
// stable while valid=1 and ready=0.
//   in_valid/in_data  : upstream -> sorter,   in_ready : sorter -> upstream
//   out_valid/out_data/out_last : sorter -> downstream, out_ready : downstream -> sorter
// Modports: master = the environment driving/consuming the streams,
//           slave  = the sorter.
interface sort_seq_ctrl_if
  import sort_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_C
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_seq_ctrl_cmp.sv
// Comparator_4bit
// Unsigned 4-bit magnitude comparator producing a one-hot result.
// Ports:
//   i_a, i_b : operands A and B
//   o_r      : o_r[CMP_GT_BIT] = A>B, o_r[CMP_EQ_BIT] = A==B, o_r[CMP_LT_BIT] = A<B
module Comparator_4bit
  import sort_seq_pkg::*;
(
  input  logic [WIDTH_C-1:0] i_a,
  input  logic [WIDTH_C-1:0] i_b,
  output logic [2:0]         o_r
);
  always_comb begin
    o_r             = '0;
    o_r[CMP_GT_BIT] = (i_a >  i_b);
    o_r[CMP_EQ_BIT] = (i_a == i_b);
    o_r[CMP_LT_BIT] = (i_a <  i_b);
  end
endmodule

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl
// Collects DEPTH samples, bubble-sorts them in place using one shared
// comparator (one compare per clock), then streams them out.
// Build option: define SORT_SEQ_DESC_EN for descending output order.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : stream interface (slave modport), in_* and out_* handshakes
//   busy      : high while sorting or streaming out
//   dbg_state : current FSM state
module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int DEPTH = 4,   // 2..8
  parameter int WIDTH = WIDTH_C
)(
  input  logic             clk,
  input  logic             rst_n,
  sort_seq_ctrl_if.slave   bus,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_J   = IW'(DEPTH - 2);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [IW-1:0]    r_wr_idx;
  logic [IW-1:0]    r_rd_idx;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_pass;
  logic             r_swap;

  logic [IW-1:0]    w_j1;
  logic [WIDTH-1:0] w_a, w_b;
  logic [2:0]       w_cmp;
  logic             w_swap;
  logic             w_in_fire, w_out_fire;
  logic             w_pass_end, w_sort_done;

  // Shared comparator: operands are the adjacent pair selected by j.
  assign w_j1 = r_j + 1'b1;
  assign w_a  = r_buf[r_j];
  assign w_b  = r_buf[w_j1];

  Comparator_4bit u_cmp (
    .i_a (w_a),
    .i_b (w_b),
    .o_r (w_cmp)
  );

  // Swap only on a strict ordering result; equal pairs never swap, which
  // keeps the sort stable.
`ifdef SORT_SEQ_DESC_EN
  assign w_swap = (w_cmp == 3'(1 << CMP_LT_BIT));
`else
  assign w_swap = (w_cmp == 3'(1 << CMP_GT_BIT));
`endif

  assign w_in_fire  = (r_state == LOAD) && bus.in_valid;
  assign w_out_fire = (r_state == OUT)  && bus.out_ready;
  assign w_pass_end = (r_j == LAST_J);
  // Leave after a pass with no swaps (including this cycle's compare), or
  // after DEPTH-1 passes, which is enough for any input.
  assign w_sort_done = w_pass_end && (!(r_swap || w_swap) || (r_pass == LAST_J));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_next;
  end

  // Next state and outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    case (r_state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (w_in_fire && (r_wr_idx == LAST_IDX)) w_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (w_sort_done) w_next = OUT;
      end
      OUT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = r_buf[r_rd_idx];
        bus.out_last  = (r_rd_idx == LAST_IDX);
        if (w_out_fire && (r_rd_idx == LAST_IDX)) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  assign dbg_state = r_state;

  // Buffer, indices and swap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_j      <= '0;
      r_pass   <= '0;
      r_swap   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_fire) begin
            r_buf[r_wr_idx] <= bus.in_data;
            r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
          end
        end
        SORT: begin
          if (w_swap) begin
            r_buf[r_j]  <= w_b;
            r_buf[w_j1] <= w_a;
            r_swap      <= 1'b1;
          end
          if (w_pass_end) begin
            // Pass boundary: the flag for the next pass starts clear.
            r_j    <= '0;
            r_swap <= 1'b0;
            r_pass <= w_sort_done ? '0 : r_pass + 1'b1;
          end else begin
            r_j <= w_j1;
          end
        end
        OUT: begin
          if (w_out_fire) r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
module tb_sort_seq_ctrl;
  import sort_seq_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;

  always #5 clk = ~clk;

  sort_seq_ctrl_if #(.WIDTH(WIDTH_C)) bus ();

  sort_seq_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH_C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] din  [DEPTH];
    logic [3:0] dout [DEPTH];   // ascending expectation
    int         sort_cyc;
    int         stall_after;    // -1: no stall
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a stable sort of scalar values is just the multiset
  // listed in value order.
  task automatic model(input logic [3:0] d[DEPTH]);
    exp_q.delete();
`ifdef SORT_SEQ_DESC_EN
    for (int v = 15; v >= 0; v--)
`else
    for (int v = 0; v <= 15; v++)
`endif
      for (int k = 0; k < DEPTH; k++)
        if (int'(d[k]) == v) exp_q.push_back(d[k]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_batch(input logic [3:0] d[DEPTH], input bit gaps);
    for (int k = 0; k < DEPTH; k++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d[k];
      begin
        int w = 0;
        while (!bus.in_ready && w < 50) begin tick(); w++; end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts cycles spent sorting: busy while not yet presenting output.
  task automatic measure_sort(output int cyc);
    int w = 0;
    cyc = 0;
    while (!bus.out_valid && w < 200) begin
      if (busy) cyc++;
      tick();
      w++;
    end
    if (!bus.out_valid) check("sort_timeout", 0, 1);
  endtask

  task automatic drain(input int stall_after, input bit rnd_ready, input bit junk_in);
    int n = 0;
    int w = 0;
    bit stalled = 0;
    while (n < DEPTH && w < 500) begin
      if (junk_in) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 4'($urandom_range(0, 15));
      end
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == stall_after && !stalled) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'(bus.out_data), int'(exp_q[0]));
          check("stall_last", int'(bus.out_last), (n == DEPTH - 1) ? 1 : 0);
          tick();
        end
        stalled = 1;
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid) begin
        check("out_data", int'(bus.out_data), int'(exp_q[0]));
        check("out_last", int'(bus.out_last), (n == DEPTH - 1) ? 1 : 0);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      tick();
      w++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (n < DEPTH) check("drain_timeout", n, DEPTH);
    // One cycle after the final handshake the block is back in LOAD.
    check("post_busy", int'(busy), 0);
    check("post_out_valid", int'(bus.out_valid), 0);
    check("post_in_ready", int'(bus.in_ready), 1);
  endtask

  task automatic reset_mid_sort();
    logic [3:0] d[DEPTH];
    for (int k = 0; k < DEPTH; k++) d[k] = 4'(15 - k);
    load_batch(d, 1'b0);
    tick();
    check("rst_pre_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_in_ready", int'(bus.in_ready), 1);
    check("rst_async_out_valid", int'(bus.out_valid), 0);
    check("rst_async_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_post_in_ready", int'(bus.in_ready), 1);
    check("rst_post_out_valid", int'(bus.out_valid), 0);
    check("rst_post_state", int'(dbg_state), int'(LOAD));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    logic [3:0] d[DEPTH];

    vecs[0].din = '{4'd5, 4'd3, 4'd10, 4'd1};  vecs[0].dout = '{4'd1, 4'd3, 4'd5, 4'd10};
    vecs[1].din = '{4'd0, 4'd1, 4'd2, 4'd3};   vecs[1].dout = '{4'd0, 4'd1, 4'd2, 4'd3};
    vecs[2].din = '{4'd15, 4'd9, 4'd6, 4'd0};  vecs[2].dout = '{4'd0, 4'd6, 4'd9, 4'd15};
    vecs[3].din = '{4'd6, 4'd6, 4'd9, 4'd6};   vecs[3].dout = '{4'd6, 4'd6, 4'd6, 4'd9};
    vecs[4].din = '{4'd5, 4'd3, 4'd10, 4'd1};  vecs[4].dout = '{4'd1, 4'd3, 4'd5, 4'd10};
    vecs[5].din = '{4'd2, 4'd1, 4'd2, 4'd1};   vecs[5].dout = '{4'd1, 4'd1, 4'd2, 4'd2};
`ifdef SORT_SEQ_DESC_EN
    vecs[0].sort_cyc = 9; vecs[1].sort_cyc = 9; vecs[2].sort_cyc = 3;
    vecs[3].sort_cyc = 9; vecs[4].sort_cyc = 9; vecs[5].sort_cyc = 6;
`else
    vecs[0].sort_cyc = 9; vecs[1].sort_cyc = 3; vecs[2].sort_cyc = 9;
    vecs[3].sort_cyc = 6; vecs[4].sort_cyc = 9; vecs[5].sort_cyc = 9;
`endif
    for (int i = 0; i < 6; i++) vecs[i].stall_after = (i == 4) ? 2 : -1;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_last", int'(bus.out_last), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(dbg_state), int'(LOAD));
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_mid_sort();
      exp_q.delete();
      for (int k = 0; k < DEPTH; k++)
`ifdef SORT_SEQ_DESC_EN
        exp_q.push_front(vecs[i].dout[k]);
`else
        exp_q.push_back(vecs[i].dout[k]);
`endif
      load_batch(vecs[i].din, 1'b0);
      check("load_in_ready_low", int'(bus.in_ready), 0);
      measure_sort(cyc);
      check("sort_cycles", cyc, vecs[i].sort_cyc);
      drain(vecs[i].stall_after, 1'b0, 1'b0);
    end

    // Randomized batches against the reference model
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < DEPTH; k++)
        d[k] = (b % 2 == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      model(d);
      load_batch(d, 1'b1);
      measure_sort(cyc);
      check("sort_cycles_range",
            (cyc >= DEPTH - 1 && cyc <= (DEPTH - 1) * (DEPTH - 1)) ? 1 : 0, 1);
      drain(-1, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
